simon_round_controller: RTL and testbench

//  Top-level game sequencer for the Simon board. Owns the pattern register and round level.

---
 rtl/simon_pkg.sv | 17 +
 rtl/simon_lfsr8.sv | 16 +
 rtl/simon_round_controller.sv | 124 ++++++++++++
 tb/tb_simon_round_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state encoding and constants for the Simon round controller
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_INPUT  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic RESULT_WIN  = 1'b1;
  localparam logic RESULT_LOSE = 1'b0;

  localparam logic BIT_LEFT  = 1'b0;
  localparam logic BIT_RIGHT = 1'b1;

endpackage

// File: rtl/simon_lfsr8.sv
// rtl/simon_lfsr8.sv - free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) for pattern generation
module simon_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [7:0] q
);

  // Maximal-length polynomial: a nonzero seed never reaches the all-zero lock-up state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= SEED;
    else          q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/simon_round_controller.sv
// rtl/simon_round_controller.sv - Simon game sequencer: pattern, rounds, button compare, displays
module simon_round_controller
  import simon_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 27,
  parameter int unsigned MAX_LEVEL = 7,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       flash_enable,
  output logic [2:0] flash_count,
  output logic [7:0] flash_pattern,
  input  logic       flash_done,
  output logic       msg_start,
  output logic       msg_result,
  input  logic       msg_finish,
  output logic [2:0] level,
  output logic       busy
);

  localparam logic [2:0] LAST_LEVEL = 3'(MAX_LEVEL);

  state_t               state, state_next;
  logic [2:0]           idx, idx_next;
  logic [2:0]           level_next;
  logic [TIMEOUT_W-1:0] timeout, timeout_next;
  logic                 result_next;
  logic [7:0]           pattern_next;
  logic [7:0]           lfsr_q;
  logic                 press_one;
  logic                 press_bit;

  simon_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock  (clock),
    .reset_n(reset_n),
    .q      (lfsr_q)
  );

  assign press_one = btn_left ^ btn_right;
  assign press_bit = btn_right ? BIT_RIGHT : BIT_LEFT;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      level         <= '0;
      timeout       <= '0;
      msg_result    <= 1'b0;
      flash_pattern <= '0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      level         <= level_next;
      timeout       <= timeout_next;
      msg_result    <= result_next;
      flash_pattern <= pattern_next;
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    level_next   = level;
    timeout_next = timeout;
    result_next  = msg_result;
    pattern_next = flash_pattern;
    case (state)
      ST_IDLE: begin
        if (btn_start) begin
          pattern_next = lfsr_q;
          level_next   = '0;
          state_next   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (flash_done) begin
          idx_next     = '0;
          timeout_next = '0;
          state_next   = ST_INPUT;
        end
      end
      ST_INPUT: begin
        if (press_one) begin
          timeout_next = '0;
          if (press_bit != flash_pattern[idx]) begin
            result_next = RESULT_LOSE;
            state_next  = ST_RESULT;
          end else if (idx < level) begin
            idx_next = idx + 3'd1;
          end else if (level == LAST_LEVEL) begin
            result_next = RESULT_WIN;
            state_next  = ST_RESULT;
          end else begin
            // Passing through SHOW from INPUT guarantees a low flash_enable cycle first.
            level_next = level + 3'd1;
            state_next = ST_SHOW;
          end
        end else if (!btn_left && !btn_right) begin
          if (timeout == '1) begin
            result_next = RESULT_LOSE;
            state_next  = ST_RESULT;
          end else begin
            timeout_next = timeout + TIMEOUT_W'(1);
          end
        end
      end
      ST_RESULT: begin
        if (msg_finish) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Display strobes decode straight from state so reset drops them without waiting for a clock.
  assign flash_enable = (state == ST_SHOW);
  assign flash_count  = level;
  assign msg_start    = (state == ST_RESULT);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_simon_round_controller.sv
// tb/tb_simon_round_controller.sv - scoreboard bench with random games against a game-level model
module tb_simon_round_controller;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clock, reset_n;
  logic       btn_start, btn_left, btn_right;
  logic       flash_enable, flash_done;
  logic [2:0] flash_count;
  logic [7:0] flash_pattern;
  logic       msg_start, msg_result, msg_finish;
  logic [2:0] level;
  logic       busy;

  simon_round_controller #(.TIMEOUT_W(6), .MAX_LEVEL(7), .LFSR_SEED(SEED)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .btn_start    (btn_start),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .flash_enable (flash_enable),
    .flash_count  (flash_count),
    .flash_pattern(flash_pattern),
    .flash_done   (flash_done),
    .msg_start    (msg_start),
    .msg_result   (msg_result),
    .msg_finish   (msg_finish),
    .level        (level),
    .busy         (busy)
  );

  typedef struct {
    bit         is_msg;
    logic [2:0] count;
    logic [7:0] pat;
    logic       res;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc;
  logic        fe_prev = 1'b0;
  logic        ms_prev = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Pattern register contents after n shifts of the x^8+x^6+x^5+x^4+1 sequence from the seed.
  function automatic logic [7:0] lfsr_after(input int unsigned n);
    logic [7:0] s;
    s = SEED;
    for (int unsigned k = 0; k < n; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every new SHOW or RESULT presentation must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset_n) begin
      fe_prev <= 1'b0;
      ms_prev <= 1'b0;
    end else begin
      if (flash_enable && !fe_prev) begin
        if (sb.size() == 0) chk("unexpected_show", 1, 0);
        else begin
          e = sb.pop_front();
          chk("show_kind", {31'd0, e.is_msg}, 0);
          chk("show_count", flash_count, e.count);
          chk("show_level", level, e.count);
          chk("show_pattern", flash_pattern, e.pat);
        end
      end
      if (msg_start && !ms_prev) begin
        if (sb.size() == 0) chk("unexpected_msg", 1, 0);
        else begin
          e = sb.pop_front();
          chk("msg_kind", {31'd0, e.is_msg}, 1);
          chk("msg_result", msg_result, e.res);
          chk("msg_level", level, e.count);
          chk("msg_flash_off", flash_enable, 0);
        end
      end
      fe_prev <= flash_enable;
      ms_prev <= msg_start;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_show(input logic [2:0] cnt, input logic [7:0] pat);
    sb.push_back('{is_msg: 1'b0, count: cnt, pat: pat, res: 1'b0});
  endtask

  task automatic push_msg(input logic [2:0] lvl, input logic res);
    sb.push_back('{is_msg: 1'b1, count: lvl, pat: 8'h00, res: res});
  endtask

  task automatic press(input logic b);
    btn_left = ~b; btn_right = b;
    tick(1);
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic junk(input int k);
    case (k)
      0: btn_left = 1'b1;
      1: btn_right = 1'b1;
      2: btn_start = 1'b1;
      default: begin btn_left = 1'b1; btn_right = 1'b1; end
    endcase
    tick(1);
    btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
  endtask

  task automatic wait_show();
    int t = 0;
    while (flash_enable !== 1'b1 && t < 300) begin tick(1); t++; end
    chk("wait_show", flash_enable, 1);
  endtask

  task automatic wait_msg();
    int t = 0;
    while (msg_start !== 1'b1 && t < 300) begin tick(1); t++; end
    chk("wait_msg", msg_start, 1);
  endtask

  task automatic play_game(input int err_level, input int err_idx, input bit do_timeout);
    logic [7:0] pat;
    bit         done;
    int         final_lvl;
    pat = lfsr_after(cyc);
    push_show(3'd0, pat);
    btn_start = 1'b1; tick(1); btn_start = 1'b0;
    done = 0;
    final_lvl = 7;
    for (int lvl = 0; lvl <= 7 && !done; lvl++) begin
      wait_show();
      if ($urandom_range(0, 1) == 1) begin
        junk(int'($urandom_range(0, 3)));
        chk("show_ignore_enable", flash_enable, 1);
        chk("show_ignore_level", level, lvl);
      end
      tick(int'($urandom_range(0, 3)));
      flash_done = 1'b1; tick(1); flash_done = 1'b0;
      chk("input_flash_low", flash_enable, 0);
      if (do_timeout && lvl == err_level) begin
        push_msg(3'(lvl), 1'b0);
        junk(3);
        tick(61);
        chk("timeout_early", msg_start, 0);
        done = 1;
        final_lvl = lvl;
      end
      for (int i = 0; i <= lvl && !done; i++) begin
        tick(int'($urandom_range(0, 2)));
        if ($urandom_range(0, 3) == 0) junk(int'($urandom_range(2, 3)));
        if (!do_timeout && lvl == err_level && i == err_idx) begin
          push_msg(3'(lvl), 1'b0);
          press(~pat[i]);
          done = 1;
          final_lvl = lvl;
        end else begin
          if (i == lvl) begin
            if (lvl == 7) begin push_msg(3'd7, 1'b1); done = 1; end
            else push_show(3'(lvl + 1), pat);
          end
          press(pat[i]);
        end
      end
    end
    wait_msg();
    junk(int'($urandom_range(0, 3)));
    chk("result_hold", msg_start, 1);
    tick(int'($urandom_range(0, 3)));
    msg_finish = 1'b1; tick(1); msg_finish = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_msg_start", msg_start, 0);
    chk("final_level", level, final_lvl);
    chk("idle_flash", flash_enable, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int el;
    reset_n = 1'b0;
    btn_start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    flash_done = 1'b0; msg_finish = 1'b0;
    tick(3);
    chk("rst_flash_enable", flash_enable, 0);
    chk("rst_flash_count", flash_count, 0);
    chk("rst_flash_pattern", flash_pattern, 0);
    chk("rst_msg_start", msg_start, 0);
    chk("rst_msg_result", msg_result, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);

    // Start on the first edge after release: the seed itself is captured.
    reset_n = 1'b1;
    btn_start = 1'b1;
    push_show(3'd0, 8'hA5);
    tick(1);
    btn_start = 1'b0;
    wait_show();
    chk("first_pattern", flash_pattern, 8'hA5);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_flash_enable", flash_enable, 0);
    chk("async_busy", busy, 0);
    chk("async_level", level, 0);
    chk("async_pattern", flash_pattern, 0);
    chk("async_msg_start", msg_start, 0);
    @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    tick(3);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_flash", flash_enable, 0);

    play_game(1, 1, 1'b0);
    play_game(8, 0, 1'b0);
    play_game(0, 0, 1'b1);
    play_game(3, 0, 1'b1);
    repeat (5) begin
      el = int'($urandom_range(0, 8));
      play_game(el, (el < 8) ? int'($urandom_range(0, el)) : 0, 1'b0);
    end

    tick(5);
    chk("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
